// File: rtl/reg_file_idu.sv
// Register file for an 8-bit CPU core: byte registers, SP/PC, address mux and
// the increment/decrement/adjust unit that feeds 16-bit writebacks.
module reg_file_idu (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  s_ab,
    input  logic [3:0]  s_db,
    input  logic [3:0]  t_db,
    input  logic [7:0]  wb_data,
    input  logic [7:0]  mem_rdata,
    input  logic [1:0]  idu,
    input  logic        alu_carry,
    input  logic [1:0]  s_rr_wb,
    input  logic [2:0]  t_rr_wb,
    input  logic        wr_pc,
    output logic [15:0] addr,
    output logic [7:0]  rd_data,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    output logic [7:0]  reg_a,
    output logic [3:0]  flags,
    output logic [15:0] sp,
    output logic [15:0] pc
);

    typedef enum logic [2:0] {
        AB_WZ, AB_BC, AB_DE, AB_HL, AB_AF, AB_SP, AB_PC, AB_PCH_ZERO
    } ab_sel_e;

    typedef enum logic [3:0] {
        DB_NONE, DB_Z, DB_W, DB_B, DB_C, DB_D, DB_E, DB_H, DB_L,
        DB_SPH, DB_SPL, DB_PCH, DB_PCL, DB_A, DB_F, DB_MEM
    } db_sel_e;

    typedef enum logic [1:0] {IDU_INC, IDU_DEC, IDU_ADJ, IDU_PASS} idu_op_e;
    typedef enum logic [1:0] {RR_NONE, RR_IDU, RR_WZ, RR_RSVD}     rr_src_e;

    typedef struct packed {
        logic [7:0]  a;
        logic [3:0]  f;
        logic [7:0]  b, c, d, e, h, l, w, z;
        logic [15:0] sp, pc;
    } regs_t;

    regs_t       regs_q, regs_d;
    logic [15:0] idu_out;
    logic [15:0] rr_data;
    logic        rr_en;
    logic [7:0]  adj;

    always_comb begin
        unique case (ab_sel_e'(s_ab))
            AB_WZ:       addr = {regs_q.w, regs_q.z};
            AB_BC:       addr = {regs_q.b, regs_q.c};
            AB_DE:       addr = {regs_q.d, regs_q.e};
            AB_HL:       addr = {regs_q.h, regs_q.l};
            AB_AF:       addr = {regs_q.a, regs_q.f, 4'h0};
            AB_SP:       addr = regs_q.sp;
            AB_PC:       addr = regs_q.pc;
            AB_PCH_ZERO: addr = {regs_q.pc[15:8], 8'h00};
            default:     addr = 16'h0000;
        endcase
    end

    // ADJ corrects the high byte after a signed 8-bit offset was added to the low byte.
    always_comb begin
        adj = 8'h00;
        if (alu_carry && !regs_q.z[7]) begin
            adj = 8'h01;
        end else if (!alu_carry && regs_q.z[7]) begin
            adj = 8'hFF;
        end
        unique case (idu_op_e'(idu))
            IDU_INC: idu_out = addr + 16'd1;
            IDU_DEC: idu_out = addr - 16'd1;
            IDU_ADJ: idu_out = {addr[15:8] + adj, addr[7:0]};
            default: idu_out = addr;
        endcase
    end

    always_comb begin
        unique case (db_sel_e'(s_db))
            DB_Z:    rd_data = regs_q.z;
            DB_W:    rd_data = regs_q.w;
            DB_B:    rd_data = regs_q.b;
            DB_C:    rd_data = regs_q.c;
            DB_D:    rd_data = regs_q.d;
            DB_E:    rd_data = regs_q.e;
            DB_H:    rd_data = regs_q.h;
            DB_L:    rd_data = regs_q.l;
            DB_SPH:  rd_data = regs_q.sp[15:8];
            DB_SPL:  rd_data = regs_q.sp[7:0];
            DB_PCH:  rd_data = regs_q.pc[15:8];
            DB_PCL:  rd_data = regs_q.pc[7:0];
            DB_A:    rd_data = regs_q.a;
            DB_F:    rd_data = {regs_q.f, 4'h0};
            DB_MEM:  rd_data = mem_rdata;
            default: rd_data = 8'h00;
        endcase
    end

    assign rr_en   = ((s_rr_wb == RR_IDU) || (s_rr_wb == RR_WZ)) && (t_rr_wb != 3'd7);
    assign rr_data = (s_rr_wb == RR_IDU) ? idu_out : {regs_q.w, regs_q.z};

    // Later stages overwrite earlier ones: PC load, then pair writeback, then byte write.
    always_comb begin
        // NOTE: start from the held value so every path assigns regs_d and no latch is inferred.
        regs_d = regs_q;
        if (wr_pc) begin
            regs_d.pc = idu_out;
        end
        if (rr_en) begin
            unique case (ab_sel_e'(t_rr_wb))
                AB_WZ:   {regs_d.w, regs_d.z} = rr_data;
                AB_BC:   {regs_d.b, regs_d.c} = rr_data;
                AB_DE:   {regs_d.d, regs_d.e} = rr_data;
                AB_HL:   {regs_d.h, regs_d.l} = rr_data;
                AB_AF:   {regs_d.a, regs_d.f} = rr_data[15:4];
                AB_SP:   regs_d.sp = rr_data;
                AB_PC:   regs_d.pc = rr_data;
                default: ;
            endcase
        end
        unique case (db_sel_e'(t_db))
            DB_Z:    regs_d.z       = wb_data;
            DB_W:    regs_d.w       = wb_data;
            DB_B:    regs_d.b       = wb_data;
            DB_C:    regs_d.c       = wb_data;
            DB_D:    regs_d.d       = wb_data;
            DB_E:    regs_d.e       = wb_data;
            DB_H:    regs_d.h       = wb_data;
            DB_L:    regs_d.l       = wb_data;
            DB_SPH:  regs_d.sp[15:8] = wb_data;
            DB_SPL:  regs_d.sp[7:0]  = wb_data;
            DB_PCH:  regs_d.pc[15:8] = wb_data;
            DB_PCL:  regs_d.pc[7:0]  = wb_data;
            DB_A:    regs_d.a       = wb_data;
            DB_F:    regs_d.f       = wb_data[7:4];
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            regs_q    <= '0;
            regs_q.sp <= 16'hFFFE;
        end else begin
            // NOTE: non-blocking so every register updates from the pre-edge values.
            regs_q <= regs_d;
        end
    end

    assign mem_we    = (t_db == DB_MEM);
    assign mem_wdata = rd_data;
    assign reg_a     = regs_q.a;
    assign flags     = regs_q.f;
    assign sp        = regs_q.sp;
    assign pc        = regs_q.pc;

endmodule

// File: tb/tb_reg_file_idu.sv
// Self-checking bench for reg_file_idu: directed scenarios plus random cycles,
// checked by a scoreboard fed from a byte-array reference model.
module tb_reg_file_idu;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  s_ab;
    logic [3:0]  s_db, t_db;
    logic [7:0]  wb_data, mem_rdata;
    logic [1:0]  idu;
    logic        alu_carry;
    logic [1:0]  s_rr_wb;
    logic [2:0]  t_rr_wb;
    logic        wr_pc;
    logic [15:0] addr;
    logic [7:0]  rd_data;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  reg_a;
    logic [3:0]  flags;
    logic [15:0] sp, pc;

    always #5 clk = ~clk;

    reg_file_idu dut (
        .clk(clk), .rst(rst), .s_ab(s_ab), .s_db(s_db), .t_db(t_db),
        .wb_data(wb_data), .mem_rdata(mem_rdata), .idu(idu), .alu_carry(alu_carry),
        .s_rr_wb(s_rr_wb), .t_rr_wb(t_rr_wb), .wr_pc(wr_pc),
        .addr(addr), .rd_data(rd_data), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .reg_a(reg_a), .flags(flags), .sp(sp), .pc(pc)
    );

    typedef struct {
        logic       rst;
        logic [2:0] s_ab;
        logic [3:0] s_db, t_db;
        logic [7:0] wb, mrd;
        logic [1:0] idu;
        logic       carry;
        logic [1:0] s_rr;
        logic [2:0] t_rr;
        logic       wr_pc;
    } stim_t;

    typedef struct {
        string       name;
        bit          chk_comb, chk_state;
        logic [15:0] addr;
        logic [7:0]  rd;
        logic        we;
        logic [15:0] pc, sp;
        logic [7:0]  a;
        logic [3:0]  fl;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: every register is a byte indexed by its data-bus code
    // (SP = bytes 9/10, PC = bytes 11/12); pairs are looked up in tables.
    logic [7:0] r [16];
    bit         model_valid = 0;
    int         hi_tab [7] = '{2, 3, 5, 7, 13, 9, 11};
    int         lo_tab [7] = '{1, 4, 6, 8, 14, 10, 12};

    function automatic int m_addr(input logic [2:0] sab);
        if (sab == 3'd7) return int'(r[11]) * 256;
        return int'(r[hi_tab[sab]]) * 256 + int'(r[lo_tab[sab]]);
    endfunction

    function automatic int m_idu(input stim_t s);
        int a, hi;
        a = m_addr(s.s_ab);
        case (s.idu)
            2'd0: return (a + 1) % 65536;
            2'd1: return (a + 65535) % 65536;
            2'd2: begin
                hi = a / 256;
                if (s.carry && !r[1][7]) hi += 1;
                else if (!s.carry && r[1][7]) hi += 255;
                return (hi % 256) * 256 + a % 256;
            end
            default: return a;
        endcase
    endfunction

    task automatic model_step(input stim_t s, output exp_t e);
        logic [7:0]  nr [16];
        logic [15:0] v, rv;
        e.chk_comb = model_valid;
        e.we       = (s.t_db == 4'd15);
        e.addr     = 16'(m_addr(s.s_ab));
        e.rd       = (s.s_db == 4'd0) ? 8'h00 : (s.s_db == 4'd15) ? s.mrd : r[s.s_db];
        if (!s.rst) begin
            for (int i = 0; i < 16; i++) r[i] = 8'h00;
            r[9]  = 8'hFF;
            r[10] = 8'hFE;
            model_valid = 1;
        end else begin
            nr = r;
            v  = 16'(m_idu(s));
            if (s.wr_pc) {nr[11], nr[12]} = v;
            if ((s.s_rr == 2'd1 || s.s_rr == 2'd2) && s.t_rr != 3'd7) begin
                rv = (s.s_rr == 2'd1) ? v : {r[2], r[1]};
                nr[hi_tab[s.t_rr]] = rv[15:8];
                nr[lo_tab[s.t_rr]] = rv[7:0];
            end
            if (s.t_db >= 4'd1 && s.t_db <= 4'd14) nr[s.t_db] = s.wb;
            nr[14] = nr[14] & 8'hF0;
            r = nr;
        end
        e.chk_state = model_valid;
        e.pc = {r[11], r[12]};
        e.sp = {r[9], r[10]};
        e.a  = r[13];
        e.fl = r[14][7:4];
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rst = 1'b1; s.s_ab = 3'd0; s.s_db = 4'd0; s.t_db = 4'd0;
        s.wb = 8'h00; s.mrd = 8'h00; s.idu = 2'd3; s.carry = 1'b0;
        s.s_rr = 2'd0; s.t_rr = 3'd7; s.wr_pc = 1'b0;
        return s;
    endfunction

    // Drives one cycle of inputs just after the falling edge and queues the expectation.
    task automatic step(input stim_t s, input string name);
        exp_t e;
        @(negedge clk);
        rst = s.rst; s_ab = s.s_ab; s_db = s.s_db; t_db = s.t_db;
        wb_data = s.wb; mem_rdata = s.mrd; idu = s.idu; alu_carry = s.carry;
        s_rr_wb = s.s_rr; t_rr_wb = s.t_rr; wr_pc = s.wr_pc;
        model_step(s, e);
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic set_reg(input logic [3:0] sel, input logic [7:0] val);
        stim_t s;
        s = idle(); s.t_db = sel; s.wb = val;
        step(s, "set_reg");
    endtask

    task automatic read_reg(input logic [3:0] sel, input logic [7:0] exp, input string name);
        stim_t s;
        s = idle(); s.s_db = sel;
        step(s, name);
        #1 check(name, rd_data, exp);
    endtask

    task automatic wz_to_pair(input logic [2:0] pair, input logic [15:0] val);
        stim_t s;
        set_reg(4'd2, val[15:8]);
        set_reg(4'd1, val[7:0]);
        s = idle(); s.s_rr = 2'd2; s.t_rr = pair;
        step(s, "wz_wb");
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares combinational outputs mid-cycle and state just after the edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q[0];
                check({e.name, " mem_we"}, mem_we, e.we);
                if (e.chk_comb) begin
                    check({e.name, " addr"}, addr, e.addr);
                    check({e.name, " rd_data"}, rd_data, e.rd);
                    check({e.name, " mem_wdata"}, mem_wdata, e.rd);
                end
                @(posedge clk);
                #1;
                if (e.chk_state) begin
                    check({e.name, " pc"}, pc, e.pc);
                    check({e.name, " sp"}, sp, e.sp);
                    check({e.name, " reg_a"}, reg_a, e.a);
                    check({e.name, " flags"}, flags, e.fl);
                end
                void'(sb_q.pop_front());
            end
        end
    end

    initial begin : driver
        stim_t s;
        rst = 1'b1; s_ab = '0; s_db = '0; t_db = '0; wb_data = '0; mem_rdata = '0;
        idu = 2'd3; alu_carry = 1'b0; s_rr_wb = '0; t_rr_wb = 3'd7; wr_pc = 1'b0;

        // Reset values
        s = idle(); s.rst = 1'b0;
        step(s, "reset");
        step(s, "reset");
        after_edge();
        check("reset pc", pc, 16'h0000);
        check("reset sp", sp, 16'hFFFE);
        check("reset reg_a", reg_a, 8'h00);
        check("reset flags", flags, 4'h0);
        s = idle(); s.s_ab = 3'd6;
        step(s, "reset addr");
        #1 check("reset addr", addr, 16'h0000);

        // PC increments, then wrap from 0xFFFF
        for (int i = 1; i <= 3; i++) begin
            s = idle(); s.s_ab = 3'd6; s.idu = 2'd0; s.wr_pc = 1'b1;
            step(s, "pc_inc");
            after_edge();
            check("pc_inc", pc, 16'(i));
        end
        wz_to_pair(3'd6, 16'hFFFF);
        after_edge();
        check("pc_load_ffff", pc, 16'hFFFF);
        s = idle(); s.s_ab = 3'd6; s.idu = 2'd0; s.wr_pc = 1'b1;
        step(s, "pc_wrap");
        after_edge();
        check("pc_wrap", pc, 16'h0000);

        // HL increment across the byte boundary, decrement wrapping below zero
        set_reg(4'd7, 8'h12);
        set_reg(4'd8, 8'hFF);
        s = idle(); s.s_ab = 3'd3; s.idu = 2'd0; s.s_rr = 2'd1; s.t_rr = 3'd3;
        step(s, "hl_inc");
        read_reg(4'd7, 8'h13, "hl_inc H");
        read_reg(4'd8, 8'h00, "hl_inc L");
        set_reg(4'd7, 8'h00);
        set_reg(4'd8, 8'h00);
        s = idle(); s.s_ab = 3'd3; s.idu = 2'd1; s.s_rr = 2'd1; s.t_rr = 3'd3;
        step(s, "hl_dec");
        read_reg(4'd7, 8'hFF, "hl_dec H");
        read_reg(4'd8, 8'hFF, "hl_dec L");

        // ADJ on PCH_ZERO, byte write overriding the low half of WZ
        wz_to_pair(3'd6, 16'h20F0);
        set_reg(4'd1, 8'h20);
        s = idle(); s.s_ab = 3'd7; s.idu = 2'd2; s.carry = 1'b1;
        s.s_rr = 2'd1; s.t_rr = 3'd0; s.t_db = 4'd1; s.wb = 8'h10;
        step(s, "adj_up");
        read_reg(4'd2, 8'h21, "adj_up W");
        read_reg(4'd1, 8'h10, "adj_up Z");
        set_reg(4'd1, 8'hF0);
        s = idle(); s.s_ab = 3'd7; s.idu = 2'd2; s.carry = 1'b0;
        s.s_rr = 2'd1; s.t_rr = 3'd0; s.t_db = 4'd1; s.wb = 8'h10;
        step(s, "adj_down");
        read_reg(4'd2, 8'h1F, "adj_down W");

        // F low nibble, memory write path
        set_reg(4'd14, 8'hFF);
        after_edge();
        check("flags_write", flags, 4'hF);
        read_reg(4'd14, 8'hF0, "f_read");
        set_reg(4'd13, 8'h5A);
        s = idle(); s.t_db = 4'd15; s.s_db = 4'd13; s.wb = 8'h33;
        step(s, "mem_write");
        #1;
        check("mem_write we", mem_we, 1'b1);
        check("mem_write wdata", mem_wdata, 8'h5A);
        after_edge();
        check("mem_write a_kept", reg_a, 8'h5A);

        // Reset discards a pending SP writeback
        wz_to_pair(3'd5, 16'h1234);
        after_edge();
        check("sp_load", sp, 16'h1234);
        s = idle(); s.rst = 1'b0; s.s_ab = 3'd5; s.idu = 2'd1; s.s_rr = 2'd1; s.t_rr = 3'd5;
        step(s, "reset_discard");
        after_edge();
        check("reset_discard sp", sp, 16'hFFFE);

        // Random cycles
        for (int i = 0; i < 2000; i++) begin
            s.rst   = ($urandom_range(0, 49) != 0);
            s.s_ab  = 3'($urandom);
            s.s_db  = 4'($urandom);
            s.t_db  = 4'($urandom);
            s.wb    = 8'($urandom);
            s.mrd   = 8'($urandom);
            s.idu   = 2'($urandom);
            s.carry = 1'($urandom);
            s.s_rr  = 2'($urandom);
            s.t_rr  = 3'($urandom);
            s.wr_pc = 1'($urandom);
            step(s, "random");
        end

        s = idle();
        step(s, "final_idle");
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        #3;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
